ahbl_sram_slave: RTL and testbench
==================================

AHBL_SRAM_SLAVE -- requirements
Module: ahbl_sram_slave

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 256, number of 32-bit words (power of two, 16..4096).
REQ-002 SHALL have parameter WAIT_STATES, default 1, number of inserted wait cycles per valid transfer (0..7).
REQ-003 clk_i  input  1  single clock; all logic on rising edge.
REQ-004 rst_i  input  1  asynchronous, active-high reset.
REQ-005 ahbl_hsel_i  input  1  slave select.
REQ-006 ahbl_haddr_i  input  32  byte address.
REQ-007 ahbl_htrans_i  input  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
REQ-008 ahbl_hwrite_i  input  1  1=write.
REQ-009 ahbl_hsize_i  input  3  0=byte, 1=half, 2=word.
REQ-010 ahbl_hburst_i  input  3  accepted and ignored.
REQ-011 ahbl_hwdata_i  input  32  write data, valid in data phase.
REQ-012 ahbl_hready_i  input  1  bus-level HREADY.
REQ-013 ahbl_hreadyout_o  output  1  slave ready.
REQ-014 ahbl_hresp_o  output  1  0=OKAY, 1=ERROR.
REQ-015 ahbl_hrdata_o  output  32  read data.

Function
REQ-016 Address phase SHALL be accepted only when hsel_i=1, hready_i=1 and htrans_i[1]=1; haddr, hwrite and hsize SHALL be latched on that edge.
REQ-017 IDLE/BUSY or hsel_i=0 with hready_i=1 SHALL produce a zero-wait OKAY response (hreadyout_o=1, hresp_o=0) in the following cycle.
REQ-018 FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
REQ-019 IDLE: on an accepted valid transfer -> WAIT if WAIT_STATES>0, else DATA; on an accepted erroneous transfer -> ERR1; otherwise stay.
REQ-020 WAIT: hreadyout_o=0 for exactly WAIT_STATES cycles (down-counter), then -> DATA.
REQ-021 DATA: hreadyout_o=1, hresp_o=0; transfer completes at this edge; a new transfer accepted at this same edge SHALL be handled per REQ-019 (back-to-back pipelining, no bubble).
REQ-022 Erroneous transfer: hsize_i>2, address misaligned to hsize (half with haddr[0]=1, word with haddr[1:0]!=0), or word address >= MEM_DEPTH.
REQ-023 ERR1: hreadyout_o=0, hresp_o=1; ERR2: hreadyout_o=1, hresp_o=1; ERR2 then behaves as DATA for the next-transfer acceptance of REQ-021; erroneous transfers SHALL NOT modify memory.
REQ-024 Write SHALL update memory at the DATA-cycle edge from hwdata_i using byte enables: byte lane haddr[1:0]; half lanes {haddr[1],0}..+1; word all four.
REQ-025 Read data SHALL be driven on hrdata_o during the DATA cycle as the full 32-bit word at the latched address; non-addressed lanes carry stored memory content.
REQ-026 A read immediately following a write to the same word SHALL return the newly written bytes (no stale data).
REQ-027 hrdata_o SHALL be 0 in all cycles other than a read DATA cycle.
REQ-028 Word index SHALL be haddr[log2(MEM_DEPTH)+1:2]; upper bits are range-checked per REQ-022, never wrapped.
REQ-029 WAIT counter SHALL reload at every accepted transfer; no transfer may be accepted while hreadyout_o=0.

Reset
REQ-030 On rst_i=1 asynchronously: state=IDLE, hreadyout_o=1, hresp_o=0, hrdata_o=0, counter=0, latched controls cleared.
REQ-031 Reset during WAIT/DATA/ERR SHALL abort the transfer with no memory write; memory contents are not reset and persist.

Verification
REQ-032 WAIT_STATES=1: word write 0x0000_0010 data 0xDEADBEEF, then read 0x10 -> hreadyout low 1 cycle each, read hrdata 0xDEADBEEF, hresp 0.
REQ-033 Byte write 0xA5 to 0x13 over word 0x11223344 -> read 0x10 returns 0xA5223344.
REQ-034 Word access at 0x0000_0002 and read at 0x400 (MEM_DEPTH=256) -> each gets ERR1 (hreadyout 0, hresp 1) then ERR2 (1,1); memory unchanged.
REQ-035 WAIT_STATES=0: back-to-back NONSEQ write 0x20 then read 0x20 -> hreadyout stays 1, read returns written value.
REQ-036 IDLE htrans with hsel=1, and BUSY -> OKAY, zero-wait, no memory change.
REQ-037 rst_i pulsed during WAIT of a write to 0x30 holding 0x12345678 -> outputs at reset values immediately, later read of 0x30 returns 0x12345678.

Source files
------------

// File: rtl/ahbl_sram_slave.sv
// AHB-Lite SRAM slave: address phase registered, data phase after WAIT_STATES stall cycles
// (hreadyout low), two-cycle ERROR for bad size/alignment/range; registered outputs.
module ahbl_sram_slave #(
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ahbl_hsel_i,
    input  logic [31:0] ahbl_haddr_i,
    input  logic [1:0]  ahbl_htrans_i,
    input  logic        ahbl_hwrite_i,
    input  logic [2:0]  ahbl_hsize_i,
    input  logic [2:0]  ahbl_hburst_i,
    input  logic [31:0] ahbl_hwdata_i,
    input  logic        ahbl_hready_i,
    output logic        ahbl_hreadyout_o,
    output logic        ahbl_hresp_o,
    output logic [31:0] ahbl_hrdata_o
);
    localparam int         AW = $clog2(MEM_DEPTH);
    localparam logic [2:0] WS = 3'(WAIT_STATES);

    typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2} state_e;

    state_e        state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [1:0]    lo_q, lo_d;
    logic [2:0]    size_q, size_d;
    logic          write_q, write_d;
    logic          hreadyout_q, hreadyout_d;
    logic          hresp_q, hresp_d;
    logic [31:0]   hrdata_q, hrdata_d;

    logic [31:0]   mem [MEM_DEPTH];

    logic          accept, req_err, wr_en;
    logic [AW-1:0] req_idx, rd_idx;
    logic [3:0]    wr_be;
    logic [31:0]   wr_mask, wr_word, rd_word;
    logic          unused_ok;

    assign unused_ok = ^{ahbl_hburst_i, ahbl_htrans_i[0]};

    function automatic logic [3:0] lane_en(input logic [1:0] lo, input logic [2:0] size);
        case (size)
            3'd0:    lane_en = 4'b0001 << lo;
            3'd1:    lane_en = lo[1] ? 4'b1100 : 4'b0011;
            default: lane_en = 4'b1111;
        endcase
    endfunction

    assign accept  = ahbl_hsel_i & ahbl_hready_i & ahbl_htrans_i[1] & hreadyout_q;
    assign req_idx = ahbl_haddr_i[AW+1:2];
    assign req_err = (ahbl_hsize_i > 3'd2)
                   | ((ahbl_hsize_i == 3'd1) & ahbl_haddr_i[0])
                   | ((ahbl_hsize_i == 3'd2) & (ahbl_haddr_i[1:0] != 2'b00))
                   | (|ahbl_haddr_i[31:AW+2]);

    assign wr_en  = (state_q == ST_DATA) && write_q;
    assign rd_idx = (state_q == ST_WAIT) ? idx_q : req_idx;

    // A read fetched on the same edge a write completes sees the merged word.
    always_comb begin
        wr_be   = lane_en(lo_q, size_q);
        wr_mask = '0;
        for (int b = 0; b < 4; b++) wr_mask[8*b +: 8] = {8{wr_be[b]}};
        wr_word = (mem[idx_q] & ~wr_mask) | (ahbl_hwdata_i & wr_mask);
        rd_word = (wr_en && (idx_q == rd_idx)) ? wr_word : mem[rd_idx];
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) mem[idx_q] <= wr_word;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        lo_d        = lo_q;
        size_d      = size_q;
        write_d     = write_q;
        hreadyout_d = 1'b1;
        hresp_d     = 1'b0;
        hrdata_d    = '0;
        unique case (state_q)
            ST_WAIT: begin
                if (cnt_q <= 3'd1) begin
                    state_d = ST_DATA;
                    cnt_d   = '0;
                    if (!write_q) hrdata_d = rd_word;
                end else begin
                    cnt_d       = cnt_q - 3'd1;
                    hreadyout_d = 1'b0;
                end
            end
            ST_ERR1: begin
                state_d = ST_ERR2;
                hresp_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                if (accept) begin
                    idx_d   = req_idx;
                    lo_d    = ahbl_haddr_i[1:0];
                    size_d  = ahbl_hsize_i;
                    write_d = ahbl_hwrite_i;
                    cnt_d   = WS;
                    if (req_err) begin
                        state_d     = ST_ERR1;
                        hreadyout_d = 1'b0;
                        hresp_d     = 1'b1;
                    end else if (WS != 3'd0) begin
                        state_d     = ST_WAIT;
                        hreadyout_d = 1'b0;
                    end else begin
                        state_d = ST_DATA;
                        if (!ahbl_hwrite_i) hrdata_d = rd_word;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            lo_q        <= '0;
            size_q      <= '0;
            write_q     <= 1'b0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
            hrdata_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            lo_q        <= lo_d;
            size_q      <= size_d;
            write_q     <= write_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
            hrdata_q    <= hrdata_d;
        end
    end

    assign ahbl_hreadyout_o = hreadyout_q;
    assign ahbl_hresp_o     = hresp_q;
    assign ahbl_hrdata_o    = hrdata_q;
endmodule

// File: tb/tb_ahbl_sram_slave.sv
// Two slaves (WAIT_STATES=1 and 0) decoded on one AHB-Lite bus; directed and random
// traffic is scored against a word-array model of each memory.
module tb_ahbl_sram_slave;
    localparam int DEPTH = 256;
    localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;

    typedef struct { logic [31:0] rdata; logic resp; int waits; } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        hsel1, hsel0, hwrite;
    logic [31:0] haddr, hwdata;
    logic [1:0]  htrans;
    logic [2:0]  hsize, hburst;
    logic        rdy1, rdy0, resp1, resp0;
    logic [31:0] rd1, rd0;
    logic        dsel, bus_rdy, bus_resp;
    logic [31:0] bus_rdata;

    logic [31:0] mdl [2][DEPTH];
    exp_t        exp_q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    logic        done = 1'b0;

    logic        dph = 1'b0;
    logic        wres_all, wres_any;
    int          wcnt;

    always #5 clk = ~clk;

    ahbl_sram_slave #(.MEM_DEPTH(DEPTH), .WAIT_STATES(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .ahbl_hsel_i(hsel1), .ahbl_haddr_i(haddr),
        .ahbl_htrans_i(htrans), .ahbl_hwrite_i(hwrite), .ahbl_hsize_i(hsize),
        .ahbl_hburst_i(hburst), .ahbl_hwdata_i(hwdata), .ahbl_hready_i(bus_rdy),
        .ahbl_hreadyout_o(rdy1), .ahbl_hresp_o(resp1), .ahbl_hrdata_o(rd1));

    ahbl_sram_slave #(.MEM_DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .ahbl_hsel_i(hsel0), .ahbl_haddr_i(haddr),
        .ahbl_htrans_i(htrans), .ahbl_hwrite_i(hwrite), .ahbl_hsize_i(hsize),
        .ahbl_hburst_i(hburst), .ahbl_hwdata_i(hwdata), .ahbl_hready_i(bus_rdy),
        .ahbl_hreadyout_o(rdy0), .ahbl_hresp_o(resp0), .ahbl_hrdata_o(rd0));

    // Data-phase slave select, as a bus decoder/mux would hold it.
    always @(posedge clk or posedge rst) begin
        if (rst) dsel <= 1'b0;
        else if (bus_rdy) dsel <= hsel0;
    end
    assign bus_rdy   = dsel ? rdy0  : rdy1;
    assign bus_resp  = dsel ? resp0 : resp1;
    assign bus_rdata = dsel ? rd0   : rd1;

    function automatic logic is_err(input logic [2:0] size, input logic [31:0] addr);
        if (size > 3'd2) return 1'b1;
        if ((addr % (32'd1 << size)) != 32'd0) return 1'b1;
        return (addr / 32'd4) >= 32'(DEPTH);
    endfunction

    // Presents one address phase, waits for it to be taken, then drives its write data.
    task automatic xfer(input int tgt, input logic sel, input logic [1:0] trans, input logic wr,
                        input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic track);
        exp_t e;
        int   k, nb, base, w;
        hsel1  = sel && (tgt == 1);
        hsel0  = sel && (tgt == 0);
        htrans = trans;
        hwrite = wr;
        hsize  = size;
        haddr  = addr;
        hburst = 3'($urandom_range(0, 7));
        if (track && sel && trans[1]) begin
            e.resp  = is_err(size, addr);
            e.rdata = '0;
            e.waits = e.resp ? 1 : ((tgt == 1) ? 1 : 0);
            if (!e.resp) begin
                w    = int'(addr >> 2);
                nb   = 1 << size;
                base = int'(addr[1:0]);
                if (wr) begin
                    for (int b = base; b < base + nb; b++) mdl[tgt][w][8*b +: 8] = wdata[8*b +: 8];
                end else begin
                    e.rdata = mdl[tgt][w];
                end
            end
            exp_q.push_back(e);
        end
        k = 0;
        @(negedge clk);
        while (!bus_rdy) begin
            k++;
            if (k > 40) begin
                $display("FAIL bus_hang: hready low for %0d cycles, required at most 40", k);
                $fatal(1);
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        hwdata = wdata;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            check("rst_ctl", {rdy1, resp1, rdy0, resp0}, 4'b1010);
            check("rst_rdata", {rd1, rd0}, 64'h0);
            dph = 1'b0;
        end else begin
            if (dph) begin
                if (!bus_rdy) begin
                    wcnt++;
                    wres_all = wres_all & bus_resp;
                    wres_any = wres_any | bus_resp;
                    check("wait_rdata", bus_rdata, 32'h0);
                    if (wcnt > 20) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL dphase_timeout: %0d stall cycles, required at most 20", wcnt);
                        dph = 1'b0;
                    end
                end else begin
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_dphase: data phase ended with no transfer pending");
                    end else begin
                        e = exp_q.pop_front();
                        check("waits", 64'(wcnt), 64'(e.waits));
                        check("hresp", bus_resp, e.resp);
                        check("wait_hresp", e.resp ? wres_all : wres_any, e.resp);
                        check("hrdata", bus_rdata, e.rdata);
                    end
                    dph = 1'b0;
                end
            end else begin
                check("idle_ctl", {rdy1, resp1, rdy0, resp0}, 4'b1010);
                check("idle_rdata", {rd1, rd0}, 64'h0);
            end
            if (bus_rdy && (hsel1 || hsel0) && htrans[1]) begin
                dph      = 1'b1;
                wcnt     = 0;
                wres_all = 1'b1;
                wres_any = 1'b0;
            end
        end
        if (done) begin
            check("sb_drained", 64'(exp_q.size()), 64'h0);
            $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
            $finish;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          tgt, r;
        logic        sel, wr;
        logic [1:0]  tr, lo;
        logic [2:0]  sz;
        logic [31:0] a;
        rst = 1'b1; hsel1 = 1'b0; hsel0 = 1'b0; haddr = '0; htrans = T_IDLE;
        hwrite = 1'b0; hsize = '0; hburst = '0; hwdata = '0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        // Known contents for every word the traffic below can reach.
        for (int t = 0; t < 2; t++) begin
            for (int i = 0; i < 17; i++) begin
                a = (i == 16) ? 32'd1020 : 32'(i * 4);
                xfer(t, 1'b1, T_NSEQ, 1'b1, 3'd2, a, $urandom, 1'b1);
            end
        end
        xfer(1, 1'b1, T_NSEQ, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1'b1);
        xfer(1, 1'b1, T_NSEQ, 1'b0, 3'd2, 32'h10, $urandom, 1'b1);
        xfer(1, 1'b1, T_NSEQ, 1'b1, 3'd2, 32'h10, 32'h11223344, 1'b1);
        xfer(1, 1'b1, T_NSEQ, 1'b1, 3'd0, 32'h13, 32'hA5C3C3C3, 1'b1);
        xfer(1, 1'b1, T_NSEQ, 1'b0, 3'd2, 32'h10, $urandom, 1'b1);
        xfer(1, 1'b1, T_NSEQ, 1'b1, 3'd2, 32'h02, 32'hFFFFFFFF, 1'b1);
        xfer(1, 1'b1, T_NSEQ, 1'b0, 3'd2, 32'h400, $urandom, 1'b1);
        xfer(1, 1'b1, T_NSEQ, 1'b1, 3'd2, 32'h400, 32'hFFFFFFFF, 1'b1);
        xfer(1, 1'b1, T_NSEQ, 1'b0, 3'd2, 32'h00, $urandom, 1'b1);
        xfer(0, 1'b1, T_NSEQ, 1'b1, 3'd2, 32'h20, 32'hCAFEF00D, 1'b1);
        xfer(0, 1'b1, T_NSEQ, 1'b0, 3'd2, 32'h20, $urandom, 1'b1);
        xfer(1, 1'b1, T_IDLE, 1'b1, 3'd2, 32'h20, 32'h0BADF00D, 1'b1);
        xfer(0, 1'b1, T_BUSY, 1'b1, 3'd2, 32'h20, 32'h0BADF00D, 1'b1);
        xfer(0, 1'b0, T_NSEQ, 1'b1, 3'd2, 32'h20, 32'h0BADF00D, 1'b1);
        xfer(0, 1'b1, T_NSEQ, 1'b0, 3'd2, 32'h20, $urandom, 1'b1);
        xfer(1, 1'b1, T_NSEQ, 1'b0, 3'd2, 32'h20, $urandom, 1'b1);
        // Reset lands while the second write to 0x30 is stalled; it must not reach memory.
        xfer(1, 1'b1, T_NSEQ, 1'b1, 3'd2, 32'h30, 32'h12345678, 1'b1);
        xfer(1, 1'b1, T_NSEQ, 1'b1, 3'd2, 32'h30, 32'hFFFFFFFF, 1'b0);
        hsel1 = 1'b0; hsel0 = 1'b0; htrans = T_IDLE;
        rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        xfer(1, 1'b1, T_NSEQ, 1'b0, 3'd2, 32'h30, $urandom, 1'b1);
        for (int n = 0; n < 400; n++) begin
            tgt = int'($urandom_range(0, 1));
            r   = int'($urandom_range(0, 19));
            sel = (r != 0);
            tr  = (r == 1) ? T_IDLE : (r == 2) ? T_BUSY : ($urandom_range(0, 1) == 1 ? T_SEQ : T_NSEQ);
            sz  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            r   = int'($urandom_range(0, 19));
            if (r == 0)      a = 32'h0001_0000 | $urandom;
            else if (r == 1) a = 32'h400 + 32'($urandom_range(0, 255)) * 32'd4;
            else if (r == 2) a = 32'd1020;
            else             a = 32'($urandom_range(0, 15)) * 32'd4;
            lo = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) != 0) begin
                if (sz == 3'd1) lo[0] = 1'b0;
                if (sz == 3'd2) lo = 2'b00;
            end
            a  = {a[31:2], lo};
            wr = 1'($urandom_range(0, 1));
            xfer(tgt, sel, tr, wr, sz, a, $urandom, 1'b1);
            if ($urandom_range(0, 5) == 0) xfer(0, 1'b0, T_IDLE, 1'b0, 3'd0, 32'h0, $urandom, 1'b1);
        end
        xfer(0, 1'b0, T_IDLE, 1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
        xfer(0, 1'b0, T_IDLE, 1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
        done = 1'b1;
    end
endmodule
